// File: rtl/ex_multicycle_ctrl_pkg.sv
// Shared definitions for the Execute-stage multicycle sequencer: FSM state
// encoding, default widths and the opcodes understood by the shared unit.
package ex_multicycle_ctrl_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int OP_W_DEF    = 4;
  localparam int RD_W_DEF    = 3;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ABORT  = 3'd4
  } mc_state_e;

  // Opcodes of the shared FPU / crypto unit
  localparam logic [3:0] OP_FADD    = 4'h0;
  localparam logic [3:0] OP_FSUB    = 4'h1;
  localparam logic [3:0] OP_FMUL    = 4'h2;
  localparam logic [3:0] OP_FDIV    = 4'h3;
  localparam logic [3:0] OP_AES_ENC = 4'h8;
  localparam logic [3:0] OP_AES_DEC = 4'h9;
  localparam logic [3:0] OP_SHA     = 4'hA;

  // States in which the op owns EX and the front of the pipeline must hold
  function automatic logic is_busy(input mc_state_e s);
    return (s == ST_LAUNCH) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/ex_multicycle_ctrl_timeout.sv
// Watchdog counter for an outstanding unit operation. Cleared while the op is
// launched, counts every cycle the controller waits on the unit, and flags the
// last allowed cycle. It parks at all-ones instead of wrapping.
module mc_timeout_ctr #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SAT  = '1;

  logic [CNT_W-1:0] count;

  // Count waiting cycles; clear has priority and the count saturates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/ex_multicycle_ctrl.sv
// Execute-stage sequencer for long-latency ops. Captures the forwarded
// operands at issue, launches the shared unit with a one-cycle start pulse,
// holds Fetch/Decode/Execute (and bubbles EX/MEM) until the unit answers or
// the watchdog expires, then offers the result to the EX result mux for one
// cycle. A squashed op is drained silently through ABORT.
module ex_multicycle_ctrl
  import ex_multicycle_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mc_validE,
  input  logic [OP_W-1:0]   mc_opE,
  input  logic [DATA_W-1:0] Src_AE,
  input  logic [DATA_W-1:0] Src_BE,
  input  logic              killE,
  input  logic              unit_done,
  input  logic [DATA_W-1:0] unit_result,
  output logic              unit_start,
  output logic [OP_W-1:0]   unit_op,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  output logic              stall_FDE,
  output logic              bubbleM,
  output logic              mc_result_validE,
  output logic [DATA_W-1:0] mc_resultE,
  output logic              mc_errE
);

  mc_state_e state;
  logic      issue;
  logic      timeout_hit;
  logic      ctr_clear;
  logic      ctr_enable;

  assign issue      = mc_validE && !killE;
  assign ctr_clear  = (state == ST_LAUNCH);
  assign ctr_enable = (state == ST_WAIT) || (state == ST_ABORT);

  mc_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (ctr_clear),
    .enable   (ctr_enable),
    .terminal (timeout_hit)
  );

  // Sequencer FSM; start, result-valid and error are registered one-cycle pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      unit_start       <= 1'b0;
      unit_op          <= '0;
      unit_a           <= '0;
      unit_b           <= '0;
      mc_result_validE <= 1'b0;
      mc_resultE       <= '0;
      mc_errE          <= 1'b0;
    end else begin
      unit_start       <= 1'b0;
      mc_result_validE <= 1'b0;
      mc_errE          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            unit_op    <= mc_opE;
            unit_a     <= Src_AE;
            unit_b     <= Src_BE;
            unit_start <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state <= killE ? ST_ABORT : ST_WAIT;
        end
        ST_WAIT: begin
          if (killE) begin
            state <= ST_ABORT;
          end else if (unit_done) begin
            mc_resultE       <= unit_result;
            mc_result_validE <= 1'b1;
            state            <= ST_DONE;
          end else if (timeout_hit) begin
            mc_resultE       <= '0;
            mc_result_validE <= 1'b1;
            mc_errE          <= 1'b1;
            state            <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_ABORT: begin
          if (unit_done || timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pipeline hold: immediate on issue, held while busy, and any op reaching EX during ABORT waits
  always_comb begin
    stall_FDE = 1'b0;
    if (rst) begin
      if (is_busy(state)) begin
        stall_FDE = 1'b1;
      end else if (state == ST_IDLE) begin
        stall_FDE = issue;
      end else if (state == ST_ABORT) begin
        stall_FDE = mc_validE;
      end
    end
    bubbleM = stall_FDE;
  end

endmodule

// File: tb/tb_ex_multicycle_ctrl.sv
// Self-checking bench for ex_multicycle_ctrl. A behavioural unit model answers
// a chosen number of cycles after each start pulse; expectations come from the
// op-level timing rules (issue, launch, wait, done) computed arithmetically.
module tb_ex_multicycle_ctrl;
  import ex_multicycle_ctrl_pkg::*;

  localparam int DW = 16;
  localparam int OW = 4;
  localparam int TO = 64;

  logic          clk;
  logic          rst;
  logic          mc_validE;
  logic [OW-1:0] mc_opE;
  logic [DW-1:0] Src_AE;
  logic [DW-1:0] Src_BE;
  logic          killE;
  logic          unit_done;
  logic [DW-1:0] unit_result;
  logic          unit_start;
  logic [OW-1:0] unit_op;
  logic [DW-1:0] unit_a;
  logic [DW-1:0] unit_b;
  logic          stall_FDE;
  logic          bubbleM;
  logic          mc_result_validE;
  logic [DW-1:0] mc_resultE;
  logic          mc_errE;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    int          starts;
    int          start_cyc;
    int          stalls;
    int          done_cyc;
    logic [15:0] res;
    logic        err;
    int          bub_bad;
    int          frz_bad;
    bit          finished;
  } obs_t;

  ex_multicycle_ctrl #(
    .DATA_W  (DW),
    .OP_W    (OW),
    .TIMEOUT (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mc_validE        (mc_validE),
    .mc_opE           (mc_opE),
    .Src_AE           (Src_AE),
    .Src_BE           (Src_BE),
    .killE            (killE),
    .unit_done        (unit_done),
    .unit_result      (unit_result),
    .unit_start       (unit_start),
    .unit_op          (unit_op),
    .unit_a           (unit_a),
    .unit_b           (unit_b),
    .stall_FDE        (stall_FDE),
    .bubbleM          (bubbleM),
    .mc_result_validE (mc_result_validE),
    .mc_resultE       (mc_resultE),
    .mc_errE          (mc_errE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timing: unit answering lat cycles after start finishes then;
  // never answering (lat 0) or answering too late ends at the watchdog limit
  function automatic int eff_lat(input int lat);
    return ((lat == 0) || (lat > TO)) ? TO : lat;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and run it to its result cycle, playing the unit and
  // scrambling the forwarding paths while the pipeline is held
  task automatic applyStimulus(input logic [OW-1:0] op, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input int lat,
                               input logic [DW-1:0] res, output obs_t o);
    int cyc;
    o = '0;
    o.start_cyc = -1;
    mc_validE = 1'b1;
    killE     = 1'b0;
    mc_opE    = op;
    Src_AE    = a;
    Src_BE    = b;
    unit_done = 1'b0;
    cyc = 0;
    while (!o.finished && cyc < 300) begin
      #4;
      if (stall_FDE) o.stalls++;
      if (bubbleM !== stall_FDE) o.bub_bad++;
      if (unit_start) begin
        o.starts++;
        o.start_cyc = cyc;
      end
      if (cyc > 0 && (unit_a !== a || unit_b !== b || unit_op !== op)) o.frz_bad++;
      if (mc_result_validE) begin
        o.finished = 1'b1;
        o.done_cyc = cyc;
        o.res      = mc_resultE;
        o.err      = mc_errE;
      end
      tick();
      cyc++;
      Src_AE      = DW'($urandom);
      Src_BE      = DW'($urandom);
      unit_done   = (o.start_cyc >= 0) && (lat > 0) && (cyc == o.start_cyc + lat);
      unit_result = unit_done ? res : DW'($urandom);
    end
    mc_validE = 1'b0;
    unit_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mc_validE = 1'b1;
    killE = 1'b0;
    mc_opE = OP_FMUL;
    Src_AE = 16'h1111;
    Src_BE = 16'h2222;
    unit_done = 1'b1;
    unit_result = 16'h5555;
    tick();
    tick();
    #3;
    tests_run++;
    if ({unit_start, unit_op, unit_a, unit_b, stall_FDE, bubbleM, mc_result_validE, mc_resultE, mc_errE} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs start=%b op=%h a=%h b=%h stall=%b bub=%b v=%b r=%h e=%b want all 0",
               unit_start, unit_op, unit_a, unit_b, stall_FDE, bubbleM, mc_result_validE, mc_resultE, mc_errE);
    end
    tick();
    rst = 1'b1;
    mc_validE = 1'b0;
    unit_done = 1'b0;
    #3;
    tests_run++;
    if (stall_FDE !== 1'b0 || unit_start !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_idle stall=%b start=%b want 0 0", stall_FDE, unit_start);
    end
    tick();
  endtask

  task automatic test_basic();
    obs_t o;
    applyStimulus(OP_FADD, 16'h3C00, 16'h4000, 3, 16'h4200, o);
    tests_run++;
    if (!o.finished || o.res !== 16'h4200 || o.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_result fin=%b res=%h err=%b want 1 4200 0", o.finished, o.res, o.err);
    end
    tests_run++;
    if (o.starts != 1 || o.start_cyc != 1) begin
      tests_failed++;
      $display("[TB] FAIL basic_start count=%0d at=%0d want 1 at 1", o.starts, o.start_cyc);
    end
    tests_run++;
    if (o.stalls != 5 || o.done_cyc != 5) begin
      tests_failed++;
      $display("[TB] FAIL basic_stall stalls=%0d done_cyc=%0d want 5 5", o.stalls, o.done_cyc);
    end
    tests_run++;
    if (o.bub_bad != 0 || o.frz_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_bubble_freeze bub_bad=%0d frz_bad=%0d want 0 0", o.bub_bad, o.frz_bad);
    end
    #4;
    tests_run++;
    if (mc_result_validE !== 1'b0 || stall_FDE !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_after_done valid=%b stall=%b want 0 0", mc_result_validE, stall_FDE);
    end
    tick();
  endtask

  task automatic test_timeout();
    obs_t o;
    applyStimulus(OP_FDIV, 16'h1234, 16'h0000, 0, 16'hFFFF, o);
    tests_run++;
    if (!o.finished || o.res !== 16'h0000 || o.err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_result fin=%b res=%h err=%b want 1 0000 1", o.finished, o.res, o.err);
    end
    tests_run++;
    if (o.stalls != TO + 2 || o.done_cyc != TO + 2 || o.starts != 1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_timing stalls=%0d done_cyc=%0d starts=%0d want %0d %0d 1",
               o.stalls, o.done_cyc, o.starts, TO + 2, TO + 2);
    end
    tick();
  endtask

  task automatic test_latency_bounds();
    obs_t o;
    int lats[3];
    logic [DW-1:0] r;
    lats[0] = 1;
    lats[1] = TO;
    lats[2] = TO + 1;
    foreach (lats[i]) begin
      r = DW'($urandom_range(1, 16'hFFFF));
      applyStimulus(OP_FMUL, DW'($urandom), DW'($urandom), lats[i], r, o);
      tests_run++;
      if (!o.finished || o.done_cyc != eff_lat(lats[i]) + 2 || o.stalls != eff_lat(lats[i]) + 2 ||
          o.err !== (lats[i] > TO) || o.res !== ((lats[i] > TO) ? 16'h0000 : r)) begin
        tests_failed++;
        $display("[TB] FAIL bound_lat%0d done_cyc=%0d stalls=%0d err=%b res=%h want %0d %0d %b %h",
                 lats[i], o.done_cyc, o.stalls, o.err, o.res, eff_lat(lats[i]) + 2,
                 eff_lat(lats[i]) + 2, (lats[i] > TO), (lats[i] > TO) ? 16'h0000 : r);
      end
    end
    tick();
  endtask

  task automatic test_kill_wait();
    int any_valid;
    int any_start;
    any_valid = 0;
    any_start = 0;
    mc_validE = 1'b1;
    killE = 1'b0;
    mc_opE = OP_AES_ENC;
    Src_AE = 16'hA5A5;
    Src_BE = 16'h5A5A;
    tick();
    tick();
    tick();
    killE = 1'b1;
    #4;
    tests_run++;
    if (stall_FDE !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL kill_wait_stall stall=%b want 1", stall_FDE);
    end
    tick();
    killE = 1'b0;
    mc_validE = 1'b0;
    #4;
    tests_run++;
    if (stall_FDE !== 1'b0 || bubbleM !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL kill_stall_release stall=%b bub=%b want 0 0", stall_FDE, bubbleM);
    end
    if (mc_result_validE) any_valid++;
    tick();
    unit_done = 1'b1;
    unit_result = 16'hBEEF;
    mc_validE = 1'b1;
    #4;
    tests_run++;
    if (stall_FDE !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_newop_stall stall=%b want 1", stall_FDE);
    end
    if (mc_result_validE) any_valid++;
    tick();
    unit_done = 1'b0;
    mc_validE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #4;
      if (mc_result_validE) any_valid++;
      if (unit_start || stall_FDE) any_start++;
      tick();
    end
    tests_run++;
    if (any_valid != 0 || any_start != 0) begin
      tests_failed++;
      $display("[TB] FAIL kill_no_result valid_cycles=%0d busy_cycles=%0d want 0 0", any_valid, any_start);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1;
    obs_t o2;
    applyStimulus(OP_FADD, 16'h0101, 16'h0202, 2, 16'h0303, o1);
    applyStimulus(OP_FSUB, 16'h0404, 16'h0505, 4, 16'h0606, o2);
    tests_run++;
    if (o1.res !== 16'h0303 || o2.res !== 16'h0606 || o1.err || o2.err) begin
      tests_failed++;
      $display("[TB] FAIL b2b_results r1=%h r2=%h e=%b%b want 0303 0606 00", o1.res, o2.res, o1.err, o2.err);
    end
    tests_run++;
    if (o1.starts != 1 || o2.starts != 1 || o2.start_cyc != 1 || o2.done_cyc != 6 || o1.done_cyc != 4) begin
      tests_failed++;
      $display("[TB] FAIL b2b_timing s1=%0d s2=%0d at2=%0d d1=%0d d2=%0d want 1 1 1 4 6",
               o1.starts, o2.starts, o2.start_cyc, o1.done_cyc, o2.done_cyc);
    end
    tests_run++;
    if (o1.frz_bad != 0 || o2.frz_bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_operand_freeze bad1=%0d bad2=%0d want 0 0", o1.frz_bad, o2.frz_bad);
    end
    tick();
  endtask

  task automatic test_random();
    obs_t o;
    int lat;
    logic [DW-1:0] r;
    logic [OW-1:0] op;
    for (int n = 0; n < 16; n++) begin
      lat = $urandom_range(1, 10);
      r   = DW'($urandom);
      op  = OW'($urandom);
      applyStimulus(op, DW'($urandom), DW'($urandom), lat, r, o);
      tests_run++;
      if (!o.finished || o.res !== r || o.err !== 1'b0 || o.starts != 1 ||
          o.stalls != eff_lat(lat) + 2 || o.done_cyc != eff_lat(lat) + 2 ||
          o.bub_bad != 0 || o.frz_bad != 0) begin
        tests_failed++;
        $display("[TB] FAIL random_op%0d lat=%0d res=%h err=%b starts=%0d stalls=%0d done=%0d bub=%0d frz=%0d want res=%h stalls=%0d",
                 n, lat, o.res, o.err, o.starts, o.stalls, o.done_cyc, o.bub_bad, o.frz_bad, r, eff_lat(lat) + 2);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    bad = 0;
    mc_validE = 1'b1;
    killE = 1'b0;
    mc_opE = OP_SHA;
    Src_AE = 16'hCAFE;
    Src_BE = 16'hF00D;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({unit_start, unit_op, unit_a, unit_b, stall_FDE, bubbleM, mc_result_validE, mc_resultE, mc_errE} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_wait start=%b op=%h a=%h b=%h stall=%b bub=%b v=%b r=%h e=%b want all 0",
               unit_start, unit_op, unit_a, unit_b, stall_FDE, bubbleM, mc_result_validE, mc_resultE, mc_errE);
    end
    mc_validE = 1'b0;
    tick();
    rst = 1'b1;
    unit_done = 1'b1;
    unit_result = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      #4;
      if (mc_result_validE || stall_FDE || unit_start) bad++;
      tick();
      unit_done = 1'b0;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_late_done busy_cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_kill_idle();
    mc_validE = 1'b1;
    killE = 1'b1;
    mc_opE = OP_FADD;
    Src_AE = 16'h7777;
    Src_BE = 16'h8888;
    #4;
    tests_run++;
    if (stall_FDE !== 1'b0 || bubbleM !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL kill_idle_stall stall=%b bub=%b want 0 0", stall_FDE, bubbleM);
    end
    tick();
    mc_validE = 1'b0;
    killE = 1'b0;
    #4;
    tests_run++;
    if (unit_start !== 1'b0 || stall_FDE !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL kill_idle_start start=%b stall=%b want 0 0", unit_start, stall_FDE);
    end
    tick();
  endtask

  // Run every scenario in order, then report
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_timeout();
    test_latency_bounds();
    test_kill_wait();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    test_kill_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #400000;
    $display("[TB] FAIL watchdog simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "[TB] watchdog");
  end

endmodule
